// File: rtl/kpn_fifo_channel.sv
// kpn_fifo_channel: bounded FIFO channel with Kahn blocking semantics.
// Writes to a full channel and reads from an empty channel are refused.
//
// Ports:
//   clk       in   clock, all logic on posedge
//   rst_n     in   synchronous reset, active-low
//   wr        in   producer write request
//   data_in   in   token written when the write is accepted
//   full      out  count == DEPTH
//   rd        in   consumer read request
//   data_out  out  registered token from the last accepted read
//   rd_valid  out  one-cycle pulse, data_out holds a new token
//   empty     out  count == 0
//   max_count out  peak occupancy since reset (KPN_FIFO_WATERMARK_EN only)
//   count     out  current occupancy, 0..DEPTH
//
// Build option: define KPN_FIFO_WATERMARK_EN to add the max_count
// peak-occupancy register and port.
module kpn_fifo_channel #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] data_in,
    output logic              full,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              empty,
`ifdef KPN_FIFO_WATERMARK_EN
    output logic [CNT_W-1:0]  max_count,
`endif
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;

    logic full_w;
    logic empty_w;
    logic wr_acc;
    logic rd_acc;

    // Flags come from the registered count only, never from the pointers.
    always_comb begin
        full_w  = (count_q == DEPTH_C);
        empty_w = (count_q == '0);
        rd_acc  = rd & ~empty_w;
        // A full channel still takes a write when a read frees a slot
        // on the same edge; an empty channel never bypasses to a read.
        wr_acc  = wr & (~full_w | rd_acc);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;

        // Power-of-two depth: pointer wrap is the natural overflow.
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            data_out_d = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is not cleared by reset, but reset still blocks writes.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef KPN_FIFO_WATERMARK_EN
    logic [CNT_W-1:0] max_count_q, max_count_d;

    always_comb begin
        max_count_d = max_count_q;
        if (count_d > max_count_q) begin
            max_count_d = count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_count_q <= '0;
        end else begin
            max_count_q <= max_count_d;
        end
    end

    assign max_count = max_count_q;
`endif

    assign full     = full_w;
    assign empty    = empty_w;
    assign count    = count_q;
    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// tb_kpn_fifo_channel: directed bench for kpn_fifo_channel.
// A queue model tracks contents; read results are scoreboarded.
module tb_kpn_fifo_channel;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              wr;
    logic [DATA_W-1:0] data_in;
    logic              full;
    logic              rd;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              empty;
    logic [CNT_W-1:0]  count;
`ifdef KPN_FIFO_WATERMARK_EN
    logic [CNT_W-1:0]  max_count;
`endif

    kpn_fifo_channel #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (wr),
        .data_in  (data_in),
        .full     (full),
        .rd       (rd),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .empty    (empty),
`ifdef KPN_FIFO_WATERMARK_EN
        .max_count(max_count),
`endif
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    logic [DATA_W-1:0] mdl   [$];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] last_out;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with the given requests; the model decides acceptance
    // from its own pre-edge occupancy, then outputs are checked.
    task automatic cyc(input logic w, input logic [DATA_W-1:0] d,
                       input logic r);
        bit wa;
        bit ra;
        int n;
        logic [DATA_W-1:0] e;
        n  = mdl.size();
        ra = r && (n != 0);
        wa = w && ((n < DEPTH) || ra);
        wr = w;
        data_in = d;
        rd = r;
        if (ra) exp_q.push_back(mdl.pop_front());
        if (wa) mdl.push_back(d);
        @(posedge clk);
        #1;
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, ra});
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rd", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data_out", {16'd0, data_out}, {16'd0, e});
                last_out = e;
            end
        end else begin
            chk("data_hold", {16'd0, data_out}, {16'd0, last_out});
        end
        chk("count", {28'd0, count}, 32'(mdl.size()));
        chk("empty", {31'd0, empty}, {31'd0, mdl.size() == 0});
        chk("full", {31'd0, full}, {31'd0, mdl.size() == DEPTH});
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr = 1'b1;
        rd = 1'b1;
        data_in = 16'hDEAD;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_data_out", {16'd0, data_out}, 32'd0);
`ifdef KPN_FIFO_WATERMARK_EN
        chk("rst_max_count", {28'd0, max_count}, 32'd0);
`endif
        mdl.delete();
        exp_q.delete();
        last_out = '0;
        wr = 1'b0;
        rd = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        wr = 1'b0;
        rd = 1'b0;
        data_in = '0;
        last_out = '0;

        // Reset with both requests high.
        do_reset();

        // Order and one-clock read latency.
        for (int i = 1; i <= 3; i++) cyc(1'b1, DATA_W'(i), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
        chk("t2_last", {16'd0, data_out}, 32'h0003);
        chk("t2_empty", {31'd0, empty}, 32'd1);

        // Full: ninth write refused, eight reads in order.
        for (int i = 0; i < 9; i++) cyc(1'b1, 16'h0010 + 16'(i), 1'b0);
        chk("t3_full", {31'd0, full}, 32'd1);
        chk("t3_count", {28'd0, count}, 32'd8);
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
        chk("t3_last", {16'd0, data_out}, 32'h0017);

        // Refused read on empty has no effect.
        cyc(1'b0, '0, 1'b1);

        // Pointer wrap.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0050 + 16'(i), 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'h00A0 + 16'(i), 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
        chk("t4_last", {16'd0, data_out}, 32'h00A7);

        // Simultaneous on empty, then on full.
        do_reset();
        cyc(1'b1, 16'h0055, 1'b1);
        chk("t5_empty_cnt", {28'd0, count}, 32'd1);
        cyc(1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0C00 + 16'(i), 1'b0);
        cyc(1'b1, 16'h0BEE, 1'b1);
        chk("t5_full_cnt", {28'd0, count}, 32'd8);
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
        chk("t5_bee_last", {16'd0, data_out}, 32'h0BEE);

        // Mixed traffic, then reset mid-operation.
        for (int i = 0; i < 40; i++)
            cyc(1'($urandom_range(0, 1)), 16'($urandom),
                1'($urandom_range(0, 1)));
        for (int i = 0; i < 4; i++) cyc(1'b1, 16'h0700 + 16'(i), 1'b0);
        do_reset();
        cyc(1'b0, '0, 1'b1);

`ifdef KPN_FIFO_WATERMARK_EN
        for (int i = 0; i < 6; i++) cyc(1'b1, 16'h0100 + 16'(i), 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);
        for (int i = 0; i < 2; i++) cyc(1'b1, 16'h0200 + 16'(i), 1'b0);
        chk("wm_max", {28'd0, max_count}, 32'd6);
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, fails);
        $finish;
    end

endmodule
